// File: rtl/avr_link_pkg.sv
// avr_link_pkg: shared frame-state encoding and UART constants for the AVR serial link
package avr_link_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    localparam int UART_DATA_BITS  = 8;
    localparam int DEF_CLK_PER_BIT = 100;

endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 serializer; line and busy are registered one cycle behind the frame state
module uart_tx_core
    import avr_link_pkg::*;
#(
    parameter int CLK_PER_BIT = DEF_CLK_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [UART_DATA_BITS-1:0] data_i,
    output logic                      idle_o,
    output logic                      tx_o,
    output logic                      busy_o
);

    localparam int CW = $clog2(CLK_PER_BIT);

    state_e                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] sh_q, sh_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      last;

    assign last = cnt_q == CW'(CLK_PER_BIT - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = (state_q == START) ? 1'b0 : (state_q == DATA) ? sh_q[0] : 1'b1;
        busy_d  = state_q != IDLE;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = START;
                    sh_d    = data_i;
                end
            end
            START: begin
                if (last) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (last) begin
                    sh_d  = sh_q >> 1;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'(UART_DATA_BITS - 1))
                        state_d = STOP;
                end
            end
            STOP: begin
                if (last)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign idle_o = state_q == IDLE;
    assign tx_o   = tx_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/avr_tx_arbiter.sv
// avr_tx_arbiter: round-robin arbiter sharing the avr_rx UART pin among byte producers.
// Define AVR_TX_ARB_PRIO_EN to give requester 0 strict priority over the round-robin set.
module avr_tx_arbiter
    import avr_link_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int CLK_PER_BIT = DEF_CLK_PER_BIT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       avr_rx_busy,
    output logic                       avr_rx,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);

    logic                      sync1_q, busy_s_q;
    logic [IW-1:0]             rr_q, grant_q, win;
    logic [NUM_REQ-1:0]        ready_q, cand;
    logic [UART_DATA_BITS-1:0] win_data;
    logic                      found, idle, start, adv;
    int                        idx;

`ifdef AVR_TX_ARB_PRIO_EN
    assign cand = req_valid & ~NUM_REQ'(1);
    assign adv  = start & ~req_valid[0];
`else
    assign cand = req_valid;
    assign adv  = start;
`endif

    // Scan from the farthest offset down so the closest requester to rr_q wins.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_data = '0;
        idx      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            idx = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
            if (cand[idx]) begin
                found    = 1'b1;
                win      = IW'(idx);
                win_data = req_data[8*idx +: 8];
            end
        end
`ifdef AVR_TX_ARB_PRIO_EN
        if (req_valid[0]) begin
            found    = 1'b1;
            win      = '0;
            win_data = req_data[7:0];
        end
`endif
    end

    assign start = idle & ~busy_s_q & found;

    // Synchronizer resets busy so nothing is sent until the AVR is seen ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            busy_s_q <= 1'b1;
            rr_q     <= '0;
            grant_q  <= '0;
            ready_q  <= '0;
        end else begin
            sync1_q  <= avr_rx_busy;
            busy_s_q <= sync1_q;
            ready_q  <= start ? NUM_REQ'(1) << win : '0;
            if (start)
                grant_q <= win;
            if (adv)
                rr_q <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end
    end

    assign req_ready = ready_q;
    assign grant_id  = grant_q;

    uart_tx_core #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(start),
        .data_i (win_data),
        .idle_o (idle),
        .tx_o   (avr_rx),
        .busy_o (busy)
    );

endmodule

// File: tb/tb_avr_tx_arbiter.sv
// tb_avr_tx_arbiter: directed stimulus with a frame-timeline model checked every cycle
module tb_avr_tx_arbiter;

    localparam int N   = 4;
    localparam int CPB = 4;
    localparam int FL  = 10 * CPB;

    logic           clk = 1'b0, rst_n = 1'b0, avr_rx_busy = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           avr_rx, busy;
    logic [1:0]     grant_id;

    int   checks = 0, fails = 0;
    int   cyc = 0, acc_cyc = -1000, acc_id = 0, rr = 0, m_grant = 0;
    int   t_m, w_m, j_m, r_m, t_rel;
    logic [7:0] acc_byte = '0;
    logic [9:0] pat;
    logic s1m = 1'b1, s2m = 1'b1;
    bit   seen1 = 1'b0;
    int   acc_ids[$], acc_times[$];

    avr_tx_arbiter #(.NUM_REQ(N), .CLK_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .avr_rx_busy(avr_rx_busy),
        .avr_rx     (avr_rx),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Frame bit i of the current byte: start, eight data bits LSB first, stop.
    function automatic logic exp_bit(input int t);
        int i;
        i = (t - 1) / CPB;
        return (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : acc_byte[i-1];
    endfunction

    function automatic int id_at(input int i);
        return (i < acc_ids.size()) ? acc_ids[i] : -1;
    endfunction

    function automatic int time_at(input int i);
        return (i < acc_times.size()) ? acc_times[i] : -1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc     = 0;
            acc_cyc = -1000;
            rr      = 0;
            m_grant = 0;
            s1m     = 1'b1;
            s2m     = 1'b1;
        end else begin
            cyc++;
            t_m = cyc - acc_cyc;
            chk("req_ready", req_ready, (t_m == 0) ? (1 << acc_id) : 0);
            chk("busy", busy, (t_m >= 1 && t_m <= FL) ? 1 : 0);
            chk("avr_rx", avr_rx, (t_m >= 1 && t_m <= FL) ? exp_bit(t_m) : 1'b1);
            chk("grant_id", grant_id, m_grant);
            if (req_ready != 0) begin
                r_m = -1;
                for (int k = 0; k < N; k++)
                    if (req_ready[k]) r_m = k;
                acc_ids.push_back(r_m);
                acc_times.push_back(cyc);
                if (req_ready[1]) seen1 = 1'b1;
            end
            if (t_m >= FL && !s2m && req_valid != 0) begin
                w_m = -1;
`ifdef AVR_TX_ARB_PRIO_EN
                if (req_valid[0]) w_m = 0;
`endif
                for (int k = 0; k < N; k++) begin
                    j_m = (rr + k) % N;
`ifdef AVR_TX_ARB_PRIO_EN
                    if (w_m < 0 && j_m != 0 && req_valid[j_m]) w_m = j_m;
`else
                    if (w_m < 0 && req_valid[j_m]) w_m = j_m;
`endif
                end
`ifdef AVR_TX_ARB_PRIO_EN
                if (w_m != 0) rr = (w_m + 1) % N;
`else
                rr = (w_m + 1) % N;
`endif
                acc_cyc  = cyc + 1;
                acc_id   = w_m;
                m_grant  = w_m;
                acc_byte = req_data[8*w_m +: 8];
            end
            s2m = s1m;
            s1m = avr_rx_busy;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        acc_ids.delete();
        acc_times.delete();
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
    endtask

    task automatic wait_acc(input int n, input int limit);
        int k;
        k = 0;
        while (acc_ids.size() < n && k < limit) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("accept_timeout", (acc_ids.size() >= n) ? 1 : 0, 1);
    endtask

    initial begin
        // Idle after reset
        step(3);
        rst_n = 1'b1;
        step(20);
        chk("idle_rx", avr_rx, 1);
        chk("idle_busy", busy, 0);
        chk("idle_ready", req_ready, 0);
        chk("idle_grant", grant_id, 0);

        // Single byte 0xA5 from requester 2
        req_data[23:16] = 8'hA5;
        req_valid[2]    = 1'b1;
        wait_acc(1, 10);
        chk("t2_id", id_at(0), 2);
        chk("t2_grant", grant_id, 2);
        step(1);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        pat = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            chk("t2_bit", avr_rx, pat[i]);
            repeat (CPB) @(negedge clk);
        end
        step(FL);

        // All four requesters valid continuously
        do_reset();
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'h30 + 8'(i);
        req_valid = '1;
        wait_acc(5, 5 * (FL + 1) + 20);
        step(1);
        req_valid = '0;
        for (int i = 0; i < 5; i++) begin
`ifdef AVR_TX_ARB_PRIO_EN
            chk("t3_order", id_at(i), 0);
`else
            chk("t3_order", id_at(i), i % N);
`endif
        end
        for (int i = 0; i < 4; i++) chk("t3_gap", time_at(i + 1) - time_at(i), 41);
        step(FL);

        // Flow control raised mid-frame
        do_reset();
        req_data[15:8] = 8'h5A;
        req_valid[1]   = 1'b1;
        wait_acc(1, 20);
        step(1);
        req_valid[1] = 1'b0;
        step(10);
        avr_rx_busy     = 1'b1;
        req_data[23:16] = 8'hC3;
        req_valid[2]    = 1'b1;
        step(FL + 30);
        chk("t4_blocked", acc_ids.size(), 1);
        t_rel       = cyc + 1;
        avr_rx_busy = 1'b0;
        wait_acc(2, 10);
        chk("t4_latency", time_at(1) - t_rel, 3);
        chk("t4_id", id_at(1), 2);
        step(1);
        req_valid = '0;
        step(FL + 2);

        // Asynchronous reset during data bit 3
        do_reset();
        req_data[31:24] = 8'h3C;
        req_valid[3]    = 1'b1;
        wait_acc(1, 20);
        step(1);
        req_valid[3] = 1'b0;
        repeat (17) @(negedge clk);
        #2;
        acc_ids.delete();
        acc_times.delete();
        rst_n = 1'b0;
        #1;
        chk("t5_rx", avr_rx, 1);
        chk("t5_busy", busy, 0);
        chk("t5_ready", req_ready, 0);
        chk("t5_grant", grant_id, 0);
        req_data[7:0] = 8'h81;
        req_valid[0]  = 1'b1;
        step(2);
        rst_n = 1'b1;
        wait_acc(1, 10);
        chk("t5_first_accept", time_at(0), 4);
        chk("t5_id", id_at(0), 0);
        step(1);
        req_valid = '0;
        step(FL + 2);

        // Requester 1 withdraws while requester 3 waits
        do_reset();
        step(3);
        req_data[7:0] = 8'h11;
        req_valid[0]  = 1'b1;
        wait_acc(1, 20);
        step(1);
        req_valid[0]    = 1'b0;
        req_data[15:8]  = 8'h22;
        req_data[31:24] = 8'h33;
        req_valid[1]    = 1'b1;
        req_valid[3]    = 1'b1;
        seen1           = 1'b0;
        step(15);
        req_valid[1] = 1'b0;
        wait_acc(2, FL + 20);
        chk("t6_id", id_at(1), 3);
        chk("t6_grant", grant_id, 3);
        chk("t6_no_ready1", seen1, 0);
        step(1);
        req_valid = '0;
        step(FL + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/avr_tx_arbiter.md
# avr_tx_arbiter

Shares the single FPGA-to-AVR serial link (avr_rx pin) among several on-chip byte producers. Performs round-robin arbitration, serializes the granted byte as 8N1 UART at a fixed bit period, and honours the AVR's avr_rx_busy flow-control input. Sits between internal requesters (debug, status, command-reply logic) and the avr_rx top-level pin, replacing the idle tie-off of that pin.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8
- CLK_PER_BIT, 100, clock cycles per UART bit (50 MHz / 500 kbaud); legal range 4..65535

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester byte valid
- req_data  input  8*NUM_REQ  per-requester byte; requester i at bits [8*i+7:8*i]
- req_ready  output  NUM_REQ  one-hot, one-cycle acceptance pulse
- avr_rx_busy  input  1  AVR receive buffer full (asynchronous to clk)
- avr_rx  output  1  serial data to AVR, idle high
- grant_id  output  $clog2(NUM_REQ)  index of requester last accepted
- busy  output  1  high while a frame is in flight

## Operation
- States: IDLE, START, DATA, STOP.
- avr_rx_busy is passed through a 2-flop synchronizer (busy_s) before use.
- IDLE: if busy_s low and any req_valid high, select the winner, pulse req_ready[winner], latch req_data of winner into a shift register, update grant_id, go to START. Otherwise stay.
- Round-robin: search starts at rr_ptr, ascending with wrap at NUM_REQ; after an accept, rr_ptr = winner+1 mod NUM_REQ.
- START: avr_rx=0 for CLK_PER_BIT cycles, then DATA.
- DATA: 8 bits LSB first, CLK_PER_BIT cycles each; 3-bit bit counter; after bit 7, go to STOP.
- STOP: avr_rx=1 for CLK_PER_BIT cycles, then IDLE.
- Handshake: requester holds req_valid and req_data stable until it sees its req_ready pulse; data is sampled in the pulse cycle. Deasserting valid before acceptance is a legal withdrawal.
- busy_s is evaluated only in IDLE; a frame already started always completes even if avr_rx_busy rises mid-frame.
- Reset (async, any state, mid-frame included): state=IDLE, avr_rx=1, req_ready=0, busy=0, grant_id=0, rr_ptr=0, synchronizer flops=1 (treat the AVR as busy until proven otherwise). A truncated frame is not resumed.

## Timing
- Accept cycle N (req_ready high): the start bit drives avr_rx low from cycle N+1. busy is high from N+1 through the last stop-bit cycle.
- Frame length: 10*CLK_PER_BIT cycles. The first IDLE cycle follows, and the earliest next accept falls in that cycle. Minimum accept-to-accept spacing is 10*CLK_PER_BIT+1 cycles.
- avr_rx_busy to blocking: up to 3 cycles (2 synchronizer + 1 IDLE evaluation). A byte accepted inside that window is sent. The AVR buffer margin covers this.
- All outputs are registered; no combinational path from any input to any output.
- Bit-period counter width: $clog2(CLK_PER_BIT); counts 0..CLK_PER_BIT-1 and wraps.

## Configuration
- AVR_TX_ARB_PRIO_EN defined: requester 0 has strict priority. It wins whenever req_valid[0] is high at an IDLE decision, without updating rr_ptr. Requesters 1..NUM_REQ-1 use round-robin among themselves.
- Undefined: pure round-robin across all NUM_REQ requesters, as above.

## Structure
- Shared package avr_link_pkg: state enum (IDLE, START, DATA, STOP), UART_DATA_BITS=8, default CLK_PER_BIT constant.
- Sub-module uart_tx_core: takes a byte plus a start strobe and produces avr_rx and busy. It contains the bit counter, bit-period counter and shift register.
- The arbiter, synchronizer and handshake stay in avr_tx_arbiter.

## Test plan
1. Reset, then idle with no req_valid → avr_rx=1, busy=0, req_ready=0, grant_id=0 indefinitely.
2. Requester 2 only, data 0xA5, CLK_PER_BIT=4 → one req_ready[2] pulse. avr_rx from the next cycle is 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles. grant_id=2.
3. All four valid continuously → accept order 0,1,2,3,0 (round-robin), with accepts exactly 41 cycles apart at CLK_PER_BIT=4. With AVR_TX_ARB_PRIO_EN the order is 0,0,0… until valid[0] drops.
4. avr_rx_busy raised mid-frame → the current frame completes unchanged, and no accept occurs while it stays high. Its release is followed by an accept within 3 cycles.
5. rst_n asserted during DATA bit 3 → avr_rx=1, busy=0 immediately (async). After release, no accept until busy_s clears (2 cycles with avr_rx_busy low).
6. Requester 1 withdraws valid before its grant while requester 3 waits → requester 3 accepted. No req_ready[1] pulse, and no frame carries requester 1's data.
